imem_fetch_unit: RTL

Parametrised successor to the processor's instruction memory: word-addressed instruction storage with a registered read and a valid/ready fetch handshake toward the pipeline front end. Adds a program-load port for runtime writes, a pipeline flush, out-of-range fault reporting and a delivered-fetch counter. Sits between the PC/fetch stage and the decode stage of the core.

---
 rtl/imem_pkg.sv | 9 +
 rtl/imem_array.sv | 24 ++
 rtl/imem_fetch_unit.sv | 79 +++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, output-register state and parity helper for the fetch unit
package imem_pkg;
   localparam int PAR_MAX_W = 64;
   localparam logic [PAR_MAX_W-1:0] NOP_WORD = '0;
   typedef enum logic {EMPTY, FULL} ostate_t;
   function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x W storage, one synchronous write port, one registered read port
module imem_array #(
   parameter int DEPTH = 65536,
   parameter int AW = 16,
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   // write port; contents deliberately survive reset
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // registered read, cleared by reset so the delivered word starts at zero
   always_ff @(posedge clk)
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction memory with valid/ready fetch, program port, flush, fault and counter
// Optional parity storage and checking enabled by defining IMEM_PARITY_EN
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH = 65536,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_valid,
   input  logic              fetch_ready,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_fault,
   input  logic              flush,
   input  logic              prog_en,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [CNT_W-1:0]  fetch_cnt
`ifdef IMEM_PARITY_EN
   ,
   input  logic              prog_par_flip,
   output logic              fetch_par_err
`endif
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
`ifdef IMEM_PARITY_EN
   localparam int W = DATA_W + 1;
`else
   localparam int W = DATA_W;
`endif
   ostate_t state;
   logic f_in, p_in, re, we;
   logic [W-1:0] wword, rword;
   assign f_in = {1'b0, fetch_addr} < LIMIT;
   assign p_in = {1'b0, prog_addr} < LIMIT;
   assign fetch_valid = state == FULL;
   assign fetch_gnt = fetch_req & ~prog_en & ~flush & ~rst & (~fetch_valid | fetch_ready);
   assign re = fetch_gnt & f_in;
   assign we = prog_en & prog_we & ~rst & p_in;
   assign fetch_instr = fetch_fault ? DATA_W'(NOP_WORD) : rword[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
   assign wword = {parity(PAR_MAX_W'(prog_data)) ^ prog_par_flip, prog_data};
   assign fetch_par_err = ~fetch_fault & (rword[DATA_W] ^ parity(PAR_MAX_W'(rword[DATA_W-1:0])));
`else
   assign wword = prog_data;
`endif
   imem_array #(.DEPTH(DEPTH), .AW(AW), .W(W)) u_array (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(prog_addr[AW-1:0]),
      .wdata(wword),
      .re(re),
      .raddr(fetch_addr[AW-1:0]),
      .rdata(rword)
   );
   // output register state, fault flag and consumed-word counter; flush wins over load/drain
   always_ff @(posedge clk)
      if (rst) begin
         state <= EMPTY;
         fetch_fault <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         fetch_cnt <= fetch_cnt + CNT_W'(fetch_valid & fetch_ready);
         if (flush) state <= EMPTY;
         else if (fetch_gnt) begin
            state <= FULL;
            fetch_fault <= ~f_in;
         end else if (fetch_ready) state <= EMPTY;
      end
endmodule
